mem_arbiter: RTL and testbench

Sequencer and two-port arbiter for the 64K x 8 main memory. Accepts single-byte read/write transactions from the CPU bus unit and the DMA/loader engine, picks one, and drives the memory's address, data and READ/WRITE strobes. The memory latches on the rising edge of WRITE and drives data only while READ is high. Sits between the CPU/DMA masters and the memory, and is the only driver of the memory's inputs.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter_rr_guard.sv | 36 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the main-memory arbiter: FSM states,
// transaction owner encoding and default bus widths.
package mem_arbiter_pkg;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 8;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU and DMA request/response channels plus the memory-side pins.
// slave is the arbiter's view; master is the view of the surrounding system.
interface mem_arbiter_if import mem_arbiter_pkg::*; #(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic          dma_gnt;
  logic          dma_done;
  logic [DW-1:0] dma_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_done, dma_rdata,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_done, dma_rdata,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_guard.sv
// Winner selection: CPU has priority, but DMA is forced through after it has
// been passed over MAX_WAIT times in a row.
module rr_guard import mem_arbiter_pkg::*; #(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   idle,
  input  logic   cpu_req,
  input  logic   dma_req,
  input  logic   grant_valid,
  input  owner_t granted_owner,
  output logic   sel_dma
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt;

  assign sel_dma = dma_req && (!cpu_req || (wait_cnt == MAX_CNT));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (grant_valid && (granted_owner == OWN_DMA)) begin
      wait_cnt <= '0;
    end else if (grant_valid && dma_req) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else if (idle && !dma_req) begin
      wait_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master sequencer for the 64K x 8 main memory: one access per four
// cycles (IDLE -> SETUP -> STROBE -> HOLD) with glitch-free strobe timing.
module mem_arbiter import mem_arbiter_pkg::*; #(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          busy
);

  state_t        state, state_nxt;
  owner_t        owner_q, winner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
  logic          idle, grant, sel_dma;

  assign idle   = (state == IDLE);
  assign grant  = idle && (bus.cpu_req || bus.dma_req);
  assign winner = sel_dma ? OWN_DMA : OWN_CPU;

  rr_guard #(.MAX_WAIT(MAX_WAIT)) u_guard (
    .clk           (clk),
    .rst           (rst),
    .idle          (idle),
    .cpu_req       (bus.cpu_req),
    .dma_req       (bus.dma_req),
    .grant_valid   (grant),
    .granted_owner (winner),
    .sel_dma       (sel_dma)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Address/data registers load only on the grant edge, so the memory pins
  // stay frozen for the whole access and keep their value between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (grant) begin
        owner_q <= winner;
        if (winner == OWN_DMA) begin
          we_q    <= bus.dma_we;
          addr_q  <= bus.dma_addr;
          wdata_q <= bus.dma_wdata;
        end else begin
          we_q    <= bus.cpu_we;
          addr_q  <= bus.cpu_addr;
          wdata_q <= bus.cpu_wdata;
        end
      end
      // The data bus is only sampled while READ has been high for a full cycle.
      if ((state == STROBE) && !we_q) begin
        if (owner_q == OWN_DMA) dma_rdata_q <= bus.mem_rdata;
        else                    cpu_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt     = state;
    bus.cpu_gnt   = 1'b0;
    bus.dma_gnt   = 1'b0;
    bus.cpu_done  = 1'b0;
    bus.dma_done  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt   = SETUP;
          bus.cpu_gnt = (winner == OWN_CPU);
          bus.dma_gnt = (winner == OWN_DMA);
        end
      end
      SETUP: begin
        bus.mem_read = !we_q;
        state_nxt    = STROBE;
      end
      STROBE: begin
        bus.mem_read  = !we_q;
        bus.mem_write = we_q;
        state_nxt     = HOLD;
      end
      HOLD: begin
        bus.cpu_done = (owner_q == OWN_CPU);
        bus.dma_done = (owner_q == OWN_DMA);
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign busy          = !idle;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, transaction-level reference model and
// directed plus randomized CPU/DMA traffic.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW       = 16;
  localparam int DW       = 8;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   cyc = 0;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Physical memory: latches on the WRITE rising edge, drives data only while
  // READ is high; 8'hEE stands in for the floating bus otherwise.
  logic [7:0] phys_mem [0:65535];
  logic [7:0] ref_mem  [0:65535];
  assign bus.mem_rdata = bus.mem_read ? phys_mem[bus.mem_addr] : 8'hEE;
  always @(posedge bus.mem_write) phys_mem[bus.mem_addr] <= bus.mem_wdata;

  int tests = 0;
  int fails = 0;
  int proto_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within the cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic proto(input string name);
    proto_err++;
    $display("FAIL %s: protocol violation at cycle %0d", name, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          dma;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          gnt_cyc;
  } txn_t;

  txn_t       pend[$];
  bit         gnt_log[$];
  int         skips = 0;
  int         wr_rises = 0;
  int         writes_done = 0;
  logic [7:0] exp_cpu_rd = '0, exp_dma_rd = '0;
  logic [15:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;
  logic        prev_write = 1'b0;
  logic [15:0] prev_addr = '0;
  int          mk;
  txn_t        mt;
  bit          exp_dma;

  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      skips      = 0;
      exp_cpu_rd = '0;
      exp_dma_rd = '0;
    end else begin
      // Expected pin activity relative to the grant of the access in flight.
      if (pend.size() != 0) begin
        mk = cyc - pend[0].gnt_cyc;
        check("mem_read", bus.mem_read, !pend[0].we && (mk == 1 || mk == 2));
        check("mem_write", bus.mem_write, pend[0].we && mk == 2);
        check("mem_addr", bus.mem_addr, pend[0].addr);
        if (pend[0].we) check("mem_wdata", bus.mem_wdata, pend[0].wdata);
        if (!busy) proto("busy_low_in_txn");
      end else if (busy || bus.mem_read || bus.mem_write) begin
        proto("idle_outputs");
      end

      if (bus.cpu_done && bus.dma_done) proto("done_both");
      if (bus.cpu_done || bus.dma_done) begin
        if (pend.size() == 0) begin
          proto("done_unexpected");
        end else begin
          mt = pend.pop_front();
          check("done_owner", bus.dma_done, mt.dma);
          check("done_cycle", cyc - mt.gnt_cyc, 3);
          if (mt.we) begin
            ref_mem[mt.addr] = mt.wdata;
            writes_done++;
          end else if (mt.dma) begin
            exp_dma_rd = ref_mem[mt.addr];
          end else begin
            exp_cpu_rd = ref_mem[mt.addr];
          end
          check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
          check("dma_rdata", bus.dma_rdata, exp_dma_rd);
        end
      end

      if (bus.cpu_gnt && bus.dma_gnt) proto("gnt_both");
      if (bus.cpu_gnt || bus.dma_gnt) begin
        // DMA wins if CPU is absent, or it has already been passed over MAX_WAIT times.
        exp_dma = bus.dma_req && (!bus.cpu_req || skips >= MAX_WAIT);
        check("arb_winner", bus.dma_gnt, exp_dma);
        if (pend.size() != 0) proto("gnt_while_busy");
        if (bus.dma_gnt)
          pend.push_back('{1'b1, bus.dma_we, bus.dma_addr, bus.dma_wdata, cyc});
        else
          pend.push_back('{1'b0, bus.cpu_we, bus.cpu_addr, bus.cpu_wdata, cyc});
        gnt_log.push_back(bus.dma_gnt);
        if (bus.dma_gnt)      skips = 0;
        else if (bus.dma_req) skips++;
      end else if (!busy && pend.size() == 0 && (bus.cpu_req || bus.dma_req)) begin
        proto("gnt_missing");
      end
      if (!bus.dma_req) skips = 0;

      if (bus.mem_write && !prev_write) begin
        wr_rises++;
        last_wr_addr = bus.mem_addr;
        last_wr_data = bus.mem_wdata;
        if (bus.mem_addr !== prev_addr) proto("addr_not_settled");
      end
    end
    prev_write = bus.mem_write;
    prev_addr  = bus.mem_addr;
  end

  // ---------------- master drivers ----------------
  task automatic drive_req(input bit m, input bit r, input bit we,
                           input logic [15:0] a, input logic [7:0] d);
    if (m) begin
      bus.dma_req = r; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    end else begin
      bus.cpu_req = r; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Entered and left just after a rising edge; holds the request until granted.
  task automatic do_txn(input bit m, input bit we, input logic [15:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output int gc, output int dc);
    gc = -1;
    dc = -1;
    rd = '0;
    drive_req(m, 1'b1, we, a, d);
    for (int k = 0; k < 64 && gc < 0; k++) begin
      @(negedge clk);
      if (m ? bus.dma_gnt : bus.cpu_gnt) gc = cyc;
    end
    @(posedge clk); #2;
    drive_req(m, 1'b0, we, a, d);
    if (gc < 0) begin
      timeout(m ? "dma_gnt_wait" : "cpu_gnt_wait");
      return;
    end
    for (int k = 0; k < 8 && dc < 0; k++) begin
      @(negedge clk);
      if (m ? bus.dma_done : bus.cpu_done) begin
        dc = cyc;
        rd = m ? bus.dma_rdata : bus.cpu_rdata;
      end
    end
    @(posedge clk); #2;
    if (dc < 0) timeout(m ? "dma_done_wait" : "cpu_done_wait");
  endtask

  typedef struct {
    bit          dma;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    int gc, dc, rc, prev_dc, wr0, base;

    for (int i = 0; i < 65536; i++) phys_mem[i] = 8'(i) ^ 8'h96;
    phys_mem[16'h0100] = 8'h5A;
    phys_mem[16'h0101] = 8'hC3;
    phys_mem[16'h0020] = 8'h77;
    for (int i = 0; i < 65536; i++) ref_mem[i] = phys_mem[i];
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {bus.cpu_gnt, bus.dma_gnt, bus.cpu_done, bus.dma_done,
                       busy, bus.mem_read, bus.mem_write}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Table: single transactions issued back to back
    vecs[0] = '{1'b0, 1'b1, 16'h0010, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 8'h11, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 16'h0000, 8'h22, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 16'h1234, 8'h33, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 8'h11};
    vecs[6] = '{1'b0, 1'b0, 16'h0000, 8'h00, 8'h22};
    vecs[7] = '{1'b1, 1'b0, 16'h1234, 8'h00, 8'h33};
    vecs[8] = '{1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A};
    vecs[9] = '{1'b0, 1'b0, 16'h0101, 8'h00, 8'hC3};
    prev_dc = 0;
    for (int i = 0; i < NV; i++) begin
      wr0 = wr_rises;
      rc  = cyc;
      do_txn(vecs[i].dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, gc, dc);
      check("vec_done_latency", dc - gc, 3);
      if (i == 0) check("vec_idle_gnt", gc, rc);
      else        check("vec_back_to_back", gc, prev_dc + 1);
      if (vecs[i].we) begin
        check("vec_write_edges", wr_rises - wr0, 1);
        check("vec_write_addr", last_wr_addr, vecs[i].addr);
        check("vec_write_data", last_wr_data, vecs[i].wdata);
      end else begin
        check("vec_read_no_write", wr_rises - wr0, 0);
        check("vec_rdata", rd, vecs[i].exp_rd);
      end
      prev_dc = dc;
    end
    check("dma_rdata_held", bus.dma_rdata, 8'h5A);

    // Reset during SETUP of a CPU write
    drive_req(1'b0, 1'b1, 1'b1, 16'h0020, 8'h3C);
    @(negedge clk);
    check("abort_gnt", bus.cpu_gnt, 1);
    @(posedge clk); #2;
    drive_req(1'b0, 1'b0, 1'b1, 16'h0020, 8'h3C);
    rst = 1'b1;
    wr0 = wr_rises;
    @(negedge clk);
    check("abort_setup_write", bus.mem_write, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("abort_ctrl", {bus.cpu_done, busy, bus.mem_read, bus.mem_write}, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_mem_wdata", bus.mem_wdata, 0);
    check("abort_rdata", {bus.cpu_rdata, bus.dma_rdata}, 0);
    repeat (4) @(negedge clk);
    check("abort_no_write", wr_rises - wr0, 0);
    @(posedge clk); #2;
    do_txn(1'b0, 1'b0, 16'h0020, 8'h00, rd, gc, dc);
    check("abort_old_contents", rd, 8'h77);

    // CPU request raised during STROBE of a DMA read
    drive_req(1'b1, 1'b1, 1'b0, 16'h0100, 8'h00);
    rc = -1;
    for (int k = 0; k < 8 && rc < 0; k++) begin
      @(negedge clk);
      if (bus.dma_gnt) rc = cyc;
    end
    if (rc < 0) timeout("late_dma_gnt");
    @(posedge clk); #2;
    drive_req(1'b1, 1'b0, 1'b0, 16'h0100, 8'h00);
    @(posedge clk); #2;
    do_txn(1'b0, 1'b0, 16'h0101, 8'h00, rd, gc, dc);
    check("late_cpu_gnt_gap", gc - rc, 4);
    check("late_cpu_rdata", rd, 8'hC3);
    check("late_dma_rdata_held", bus.dma_rdata, 8'h5A);

    // Both masters requesting continuously
    base = gnt_log.size();
    fork
      begin
        logic [7:0] r1; int g1, d1;
        for (int i = 0; i < 8; i++)
          do_txn(1'b0, 1'(i), 16'h0300 + 16'(i), 8'h40 + 8'(i), r1, g1, d1);
      end
      begin
        logic [7:0] r2; int g2, d2;
        for (int i = 0; i < 2; i++)
          do_txn(1'b1, 1'b1, 16'h0310 + 16'(i), 8'h80 + 8'(i), r2, g2, d2);
      end
    join
    check("starve_grants", gnt_log.size() - base, 10);
    if (gnt_log.size() >= base + 10)
      for (int i = 0; i < 10; i++)
        check("starve_order", gnt_log[base + i], (i % (MAX_WAIT + 1)) == MAX_WAIT);

    // Randomized concurrent traffic over a small shared address window
    fork
      begin
        logic [7:0] r3; int g3, d3, gap; bit w3;
        for (int i = 0; i < 30; i++) begin
          gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge clk); #2; end
          w3 = 1'($urandom_range(0, 1));
          do_txn(1'b0, w3, 16'h0400 + 16'($urandom_range(0, 7)), 8'($urandom), r3, g3, d3);
        end
      end
      begin
        logic [7:0] r4; int g4, d4, gap; bit w4;
        for (int i = 0; i < 30; i++) begin
          gap = int'($urandom_range(0, 3));
          repeat (gap) begin @(posedge clk); #2; end
          w4 = 1'($urandom_range(0, 1));
          do_txn(1'b1, w4, 16'h0400 + 16'($urandom_range(0, 7)), 8'($urandom), r4, g4, d4);
        end
      end
    join
    repeat (6) @(negedge clk);

    check("pending_left", pend.size(), 0);
    check("write_edges_total", wr_rises, writes_done);
    check("protocol_errors", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
